demosaic_frame_ctrl: RTL and testbench

Frame-level sequencer that sits in front of the Bayer demosaic core and owns its `iValid`/`reset` pins. It accepts one Bayer frame from an upstream ready/valid stream and realigns the demosaic counters with a clear pulse before each frame. It then forwards the frame's pixels and appends zero flush pixels until every RGB output of the frame has emerged. Downstream backpressure is applied by freezing the whole demosaic pipeline, because its `iValid` is a global clock enable.

---
 rtl/demosaic_frame_ctrl.sv | 139 +++++++++++++
 tb/tb_demosaic_frame_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demosaic_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : demosaic_frame_ctrl
// Description : Frame sequencer for the Bayer demosaic core. It clears the core
//               before each frame, forwards the frame's pixels, then feeds zero
//               flush beats until every output of the frame has emerged.
// Revision    : 1.0 - initial release
// ============================================================================
module demosaic_frame_ctrl #(
    parameter int WIDTH     = 1920,
    parameter int HEIGHT    = 1080,
    parameter int FLUSH_MAX = WIDTH*4+16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       m_ready,
    output logic       dm_reset,
    output logic [7:0] dm_data,
    output logic       dm_valid,
    input  logic       dm_oValid,
    input  logic       dm_oDone,
    output logic       busy,
    output logic       frame_done,
    output logic       err_timeout,
    output logic       err_sync
);

    localparam logic [31:0] c_NPIX      = 32'(WIDTH*HEIGHT);
    localparam logic [31:0] c_FLUSH_MAX = 32'(FLUSH_MAX);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CLEAR  = 3'd1;
    localparam logic [2:0] c_STREAM = 3'd2;
    localparam logic [2:0] c_FLUSH  = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_in_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_out_cnt;
    logic        r_busy;
    logic        r_frame_done;
    logic        r_err_timeout;
    logic        r_err_sync;

    logic        w_advance;
    logic        w_accept;
    logic        w_out_count;
    logic        w_last_in;
    logic        w_last_out;
    logic        w_timeout;
    logic        w_in_frame;

    // The flush beat budget is FLUSH_MAX; the timeout cycle itself does not advance the core.
    always_comb begin
        w_advance = 1'b0;
        case (r_state)
            c_STREAM: w_advance = s_valid & m_ready;
            c_FLUSH:  w_advance = m_ready & (r_flush_cnt != c_FLUSH_MAX);
            default:  w_advance = 1'b0;
        endcase
    end

    assign w_accept    = (r_state == c_STREAM) & w_advance;
    assign w_out_count = dm_oValid & ((r_state == c_STREAM) | (r_state == c_FLUSH));
    assign w_last_in   = w_accept & (r_in_cnt == c_NPIX - 32'd1);
    assign w_last_out  = dm_oValid & (r_out_cnt == c_NPIX - 32'd1);
    assign w_timeout   = (r_flush_cnt == c_FLUSH_MAX) & ~w_last_out;
    assign w_in_frame  = (r_state == c_STREAM) | (r_state == c_FLUSH) | (r_state == c_DONE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (start) w_next_state = c_CLEAR;
            c_CLEAR:  w_next_state = c_STREAM;
            c_STREAM: if (w_last_in) w_next_state = c_FLUSH;
            c_FLUSH: begin
                if (w_last_out)
                    w_next_state = c_DONE;
                else if (w_timeout)
                    w_next_state = c_IDLE;
            end
            c_DONE:   w_next_state = start ? c_CLEAR : c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_in_cnt      <= 32'd0;
            r_flush_cnt   <= 32'd0;
            r_out_cnt     <= 32'd0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_sync    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_busy       <= (w_next_state != c_IDLE);
            r_frame_done <= (w_next_state == c_DONE);

            if (r_state == c_CLEAR) begin
                r_in_cnt    <= 32'd0;
                r_flush_cnt <= 32'd0;
                r_out_cnt   <= 32'd0;
            end else begin
                if (w_accept)
                    r_in_cnt <= r_in_cnt + 32'd1;
                if ((r_state == c_FLUSH) && w_advance)
                    r_flush_cnt <= r_flush_cnt + 32'd1;
                if (w_out_count && (r_out_cnt != c_NPIX))
                    r_out_cnt <= r_out_cnt + 32'd1;
            end

            if ((r_state == c_FLUSH) && w_timeout)
                r_err_timeout <= 1'b1;
            // Stale done pulses outside an active frame are not sync errors.
            if (dm_oDone && w_in_frame && (r_out_cnt < c_NPIX))
                r_err_sync <= 1'b1;
        end
    end

    assign s_ready     = (r_state == c_STREAM) & m_ready;
    assign dm_valid    = w_advance;
    assign dm_data     = (r_state == c_STREAM) ? s_data : 8'd0;
    assign dm_reset    = reset | (r_state == c_CLEAR);
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign err_timeout = r_err_timeout;
    assign err_sync    = r_err_sync;

endmodule
`default_nettype wire

// File: tb/tb_demosaic_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_demosaic_frame_ctrl
// Description : Scoreboard bench for demosaic_frame_ctrl with a behavioural
//               fixed-latency demosaic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demosaic_frame_ctrl;

    localparam int WIDTH     = 8;
    localparam int HEIGHT    = 4;
    localparam int FLUSH_MAX = 48;
    localparam int NPIX      = WIDTH*HEIGHT;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       m_ready;
    logic       dm_reset;
    logic [7:0] dm_data;
    logic       dm_valid;
    logic       dm_oValid;
    logic       dm_oDone;
    logic       busy;
    logic       frame_done;
    logic       err_timeout;
    logic       err_sync;

    demosaic_frame_ctrl #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .FLUSH_MAX (FLUSH_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_ready     (m_ready),
        .dm_reset    (dm_reset),
        .dm_data     (dm_data),
        .dm_valid    (dm_valid),
        .dm_oValid   (dm_oValid),
        .dm_oDone    (dm_oDone),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .err_sync    (err_sync)
    );

    always #5 clk = ~clk;

    // Behavioural core: input pixel k emerges on advance k+lat, gated by iValid.
    int         lat      = 38;
    int         odone_at = -1;
    int         adv      = 0;
    logic [7:0] mem [0:127];

    always @(posedge clk) begin
        if (dm_reset)
            adv <= 0;
        else if (dm_valid) begin
            if (adv < 128)
                mem[adv] <= dm_data;
            adv <= adv + 1;
        end
    end

    always_comb begin
        dm_oValid = dm_valid && !dm_reset && (adv >= lat) && ((adv - lat) < NPIX);
        dm_oDone  = dm_oValid && ((adv - lat) == odone_at);
    end

    int         checks    = 0;
    int         errors    = 0;
    logic [7:0] exp_q [$];
    int         out_total = 0;
    int         fd_total  = 0;
    int         dv_total  = 0;
    int         b2b_total = 0;
    logic       fd_prev   = 1'b0;
    logic       after_fd_busy = 1'b1;
    bit         mr_toggle = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every core output.
    initial begin
        logic [7:0] got;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (!m_ready)
                    chk("dm_valid_gate", {31'd0, dm_valid}, 32'd0);
                if (dm_valid)
                    dv_total++;
                if (dm_oValid) begin
                    out_total++;
                    got = mem[adv - lat];
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: actual=0x%02h required=none", got);
                    end else begin
                        want = exp_q.pop_front();
                        chk("output_data", {24'd0, got}, {24'd0, want});
                    end
                end
                if (frame_done)
                    fd_total++;
                if (fd_prev) begin
                    after_fd_busy = busy;
                    if (dm_reset)
                        b2b_total++;
                end
                fd_prev = frame_done;
            end else
                fd_prev = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = mr_toggle ? ~m_ready : 1'b1;
        end
    end

    task automatic push_frame(input logic [7:0] base);
        for (int i = 0; i < NPIX; i++)
            exp_q.push_back(base + 8'(i));
    endtask

    task automatic do_start(input bit hold);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 if (!hold) start = 1'b0;
        @(negedge clk);
        chk("clear_dm_reset", {31'd0, dm_reset}, 32'd1);
        chk("clear_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("clear_one_cycle", {31'd0, dm_reset}, 32'd0);
    endtask

    // Pixels with gaps are withheld on every third cycle.
    task automatic send_frame(input logic [7:0] base, input bit gaps, input int count);
        int idx = 0;
        int cyc = 0;
        while (idx < count && cyc < 2000) begin
            @(posedge clk); #1;
            s_valid = gaps ? ((cyc % 3) != 1) : 1'b1;
            s_data  = base + 8'(idx);
            @(negedge clk);
            if (s_valid && s_ready)
                idx++;
            cyc++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("pixels_accepted", 32'(idx), 32'(count));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    int o0, f0, d0, b0;

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h5A;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dm_reset", {31'd0, dm_reset}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_errs", {30'd0, err_timeout, err_sync}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
        chk("rst_dm_data", {24'd0, dm_data}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // 1: plain frame, full throughput
        o0 = out_total; f0 = fd_total; d0 = dv_total;
        push_frame(8'h10);
        do_start(1'b0);
        send_frame(8'h10, 1'b0, NPIX);
        wait_idle("t1_idle");
        chk("t1_outputs", 32'(out_total - o0), 32'd32);
        chk("t1_frame_done", 32'(fd_total - f0), 32'd1);
        chk("t1_advances", 32'(dv_total - d0), 32'd70);
        chk("t1_busy_after_done", {31'd0, after_fd_busy}, 32'd0);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: downstream toggling, upstream gaps
        mr_toggle = 1'b1;
        o0 = out_total; f0 = fd_total; d0 = dv_total;
        push_frame(8'h40);
        do_start(1'b0);
        send_frame(8'h40, 1'b1, NPIX);
        wait_idle("t2_idle");
        mr_toggle = 1'b0;
        chk("t2_outputs", 32'(out_total - o0), 32'd32);
        chk("t2_frame_done", 32'(fd_total - f0), 32'd1);
        chk("t2_advances", 32'(dv_total - d0), 32'd70);

        // 3: latency beyond the flush budget
        lat = 80;
        o0 = out_total; f0 = fd_total; d0 = dv_total;
        do_start(1'b0);
        send_frame(8'h70, 1'b0, NPIX);
        wait_idle("t3_idle");
        lat = 38;
        chk("t3_err_timeout", {31'd0, err_timeout}, 32'd1);
        chk("t3_err_sync", {31'd0, err_sync}, 32'd0);
        chk("t3_no_frame_done", 32'(fd_total - f0), 32'd0);
        chk("t3_no_outputs", 32'(out_total - o0), 32'd0);
        chk("t3_advances", 32'(dv_total - d0), 32'd80);

        // 4: premature done pulse
        odone_at = 20;
        o0 = out_total; f0 = fd_total;
        push_frame(8'h90);
        do_start(1'b0);
        send_frame(8'h90, 1'b0, NPIX);
        wait_idle("t4_idle");
        odone_at = -1;
        chk("t4_err_sync", {31'd0, err_sync}, 32'd1);
        chk("t4_outputs", 32'(out_total - o0), 32'd32);
        chk("t4_frame_done", 32'(fd_total - f0), 32'd1);

        // 5: reset mid-frame, then a clean frame
        do_start(1'b0);
        send_frame(8'hA0, 1'b0, 10);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_dm_reset_in_reset", {31'd0, dm_reset}, 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_dm_reset_released", {31'd0, dm_reset}, 32'd0);
        chk("t5_errs_cleared", {30'd0, err_timeout, err_sync}, 32'd0);
        chk("t5_s_ready", {31'd0, s_ready}, 32'd0);
        o0 = out_total; f0 = fd_total;
        push_frame(8'hB0);
        do_start(1'b0);
        send_frame(8'hB0, 1'b0, NPIX);
        wait_idle("t5_idle");
        chk("t5_outputs", 32'(out_total - o0), 32'd32);
        chk("t5_frame_done", 32'(fd_total - f0), 32'd1);

        // 6: start held across two frames
        o0 = out_total; f0 = fd_total; b0 = b2b_total;
        push_frame(8'hC0);
        push_frame(8'hE0);
        do_start(1'b1);
        send_frame(8'hC0, 1'b0, NPIX);
        send_frame(8'hE0, 1'b0, NPIX);
        start = 1'b0;
        wait_idle("t6_idle");
        chk("t6_outputs", 32'(out_total - o0), 32'd64);
        chk("t6_frame_done", 32'(fd_total - f0), 32'd2);
        chk("t6_back_to_back_clear", 32'(b2b_total - b0), 32'd1);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
